// File: rtl/avalanche_entropy_pkg.sv
// Shared constants, register map and FSM encoding for the avalanche entropy model.
package avalanche_entropy_pkg;

  localparam logic [7:0] ADDR_NAME0      = 8'h00;
  localparam logic [7:0] ADDR_NAME1      = 8'h01;
  localparam logic [7:0] ADDR_VERSION    = 8'h02;
  localparam logic [7:0] ADDR_CTRL       = 8'h08;
  localparam logic [7:0] ADDR_STATUS     = 8'h09;
  localparam logic [7:0] ADDR_SEED       = 8'h0a;
  localparam logic [7:0] ADDR_WORD_COUNT = 8'h0b;
  localparam logic [7:0] ADDR_RATE       = 8'h10;

  localparam logic [31:0] NAME0_WORD   = 32'h6176616c;  // "aval"
  localparam logic [31:0] NAME1_WORD   = 32'h66616b65;  // "fake"
  localparam logic [31:0] VERSION_WORD = 32'h302e3230;  // "0.20"

  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  typedef enum logic [1:0] {StIdle, StFill, StHold, StGap} state_e;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/avalanche_entropy_model_if.sv
// Register bus plus entropy valid/ack stream of the avalanche entropy model.
interface avalanche_entropy_model_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cs;
  logic                  we;
  logic [7:0]            address;
  logic [31:0]           write_data;
  logic [31:0]           read_data;
  logic                  error;
  logic [DATA_WIDTH-1:0] entropy_data;
  logic                  entropy_valid;
  logic                  entropy_ack;

  // Consumer / bus master side.
  modport master (
    output cs, we, address, write_data, entropy_ack,
    input  read_data, error, entropy_data, entropy_valid
  );

  // Entropy source side.
  modport slave (
    input  cs, we, address, write_data, entropy_ack,
    output read_data, error, entropy_data, entropy_valid
  );
endinterface

// File: rtl/avalanche_entropy_model_lfsr.sv
// 32-bit Galois LFSR with seed load (zero selects the default seed) and step enable.
module entropy_lfsr32
  import avalanche_entropy_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h11223344
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        step,
  output logic [31:0] value,
  output logic [31:0] next_value
);

  assign next_value = lfsr_next(value);

  // LFSR state; a seed load wins over a step in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= SEED;
    end else if (load) begin
      value <= (load_value == 32'h0) ? SEED : load_value;
    end else if (step) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/avalanche_entropy_model.sv
// Simulation-only avalanche entropy stand-in: deterministic LFSR words over valid/ack,
// paced by RATE, with fault injection and a repetition health check. Not real entropy.
module avalanche_entropy_model
  import avalanche_entropy_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] SEED       = 32'h11223344,
  parameter logic [7:0]  RATE_RESET = 8'd4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        noise,
  input  logic                        test_mode,
  output logic                        security_error,
  output logic                        entropy_enabled,
  output logic [7:0]                  debug,
  input  logic                        debug_update,
  avalanche_entropy_model_if.slave    bus
);

  localparam int unsigned CHUNKS = DATA_WIDTH / 32;

  logic                  ctrl_enable, ctrl_fault;
  logic [7:0]            rate, eff_rate, gap_cnt;
  logic [31:0]           word_count;
  logic                  sec_err, first_word;
  logic [DATA_WIDTH-1:0] last_word, data_q, shift_q, shift_next;
  logic                  valid_q;
  logic [2:0]            fill_cnt;
  logic                  fill_done;
  state_e                state_q, state_d;
  logic [31:0]           lfsr_value, lfsr_chunk;
  logic                  lfsr_step;
  logic                  reg_wr, seed_wr, ack_take, rep_hit;
  logic [31:0]           rd_word;
  logic                  addr_mapped, addr_ro;
  logic                  unused_bits;

  // noise is a compatibility pin only; debug needs just the low LFSR byte.
  assign unused_bits = ^{noise, lfsr_value[31:8]};

  assign entropy_enabled = ctrl_enable | test_mode;
  assign eff_rate        = test_mode ? 8'd0 : rate;
  assign reg_wr          = bus.cs & bus.we;
  assign seed_wr         = reg_wr & (bus.address == ADDR_SEED);
  assign fill_done       = (fill_cnt == 3'(CHUNKS - 1));
  // Older chunks move toward the MSBs, so the first chunk of a word ends on top.
  assign shift_next      = DATA_WIDTH'({shift_q, lfsr_chunk});
  assign ack_take        = entropy_enabled & (state_q == StHold) & bus.entropy_ack;
  assign rep_hit         = ack_take & ~first_word & (data_q == last_word);

  entropy_lfsr32 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .load       (seed_wr),
    .load_value (bus.write_data),
    .step       (lfsr_step),
    .value      (lfsr_value),
    .next_value (lfsr_chunk)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StFill;
    else       state_q <= state_d;
  end

  // Next-state logic; losing enable always returns to idle.
  always_comb begin
    state_d   = state_q;
    lfsr_step = 1'b0;
    if (!entropy_enabled) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StFill;
        StFill: begin
          lfsr_step = ~ctrl_fault;
          if (fill_done) state_d = StHold;
        end
        StHold: if (bus.entropy_ack) state_d = (eff_rate == 8'd0) ? StFill : StGap;
        StGap:  if (test_mode || gap_cnt <= 8'd1) state_d = StFill;
      endcase
    end
  end

  // Word assembly, valid flag and gap counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      shift_q  <= '0;
      valid_q  <= 1'b0;
      fill_cnt <= '0;
      gap_cnt  <= '0;
    end else if (!entropy_enabled) begin
      valid_q  <= 1'b0;
      fill_cnt <= '0;
    end else begin
      unique case (state_q)
        StIdle: fill_cnt <= '0;
        StFill: begin
          shift_q <= shift_next;
          if (fill_done) begin
            data_q   <= shift_next;
            valid_q  <= 1'b1;
            fill_cnt <= '0;
          end else begin
            fill_cnt <= fill_cnt + 3'd1;
          end
        end
        StHold: if (bus.entropy_ack) begin
          valid_q <= 1'b0;
          gap_cnt <= eff_rate;
        end
        StGap: gap_cnt <= gap_cnt - 8'd1;
      endcase
    end
  end

  // Acked-word counter and sticky repetition check; a new hit beats a STATUS clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count <= '0;
      sec_err    <= 1'b0;
      first_word <= 1'b1;
      last_word  <= '0;
    end else begin
      if (ack_take) begin
        word_count <= word_count + 32'd1;
        first_word <= 1'b0;
        last_word  <= data_q;
      end
      if (rep_hit) begin
        sec_err <= 1'b1;
      end else if (reg_wr && bus.address == ADDR_STATUS && bus.write_data[1]) begin
        sec_err <= 1'b0;
      end
    end
  end

  // Writable control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_enable <= 1'b1;
      ctrl_fault  <= 1'b0;
      rate        <= RATE_RESET;
    end else if (reg_wr) begin
      case (bus.address)
        ADDR_CTRL: {ctrl_fault, ctrl_enable} <= bus.write_data[1:0];
        ADDR_RATE: rate <= bus.write_data[7:0];
        default: ;
      endcase
    end
  end

  // Debug byte capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             debug <= 8'h00;
    else if (debug_update) debug <= lfsr_value[7:0];
  end

  // Register read mux and address classification.
  always_comb begin
    rd_word     = 32'h0;
    addr_mapped = 1'b1;
    addr_ro     = 1'b0;
    case (bus.address)
      ADDR_NAME0:      begin rd_word = NAME0_WORD;   addr_ro = 1'b1; end
      ADDR_NAME1:      begin rd_word = NAME1_WORD;   addr_ro = 1'b1; end
      ADDR_VERSION:    begin rd_word = VERSION_WORD; addr_ro = 1'b1; end
      ADDR_CTRL:       rd_word = {30'h0, ctrl_fault, ctrl_enable};
      ADDR_STATUS:     rd_word = {30'h0, sec_err, valid_q};
      ADDR_SEED:       rd_word = 32'h0;
      ADDR_WORD_COUNT: begin rd_word = word_count;   addr_ro = 1'b1; end
      ADDR_RATE:       rd_word = {24'h0, rate};
      default:         addr_mapped = 1'b0;
    endcase
  end

  assign bus.read_data     = (bus.cs && !bus.we) ? rd_word : 32'h0;
  assign bus.error         = bus.cs & (~addr_mapped | (bus.we & addr_ro));
  assign bus.entropy_data  = data_q;
  assign bus.entropy_valid = valid_q;
  assign security_error    = sec_err;

endmodule

// File: tb/tb_avalanche_entropy_model.sv
// Self-checking bench for avalanche_entropy_model (32-bit and 64-bit instances).
module tb_avalanche_entropy_model;

  localparam logic [31:0] SEED_DEF = 32'h11223344;
  localparam logic [7:0]  A_NAME0 = 8'h00, A_NAME1 = 8'h01, A_VER = 8'h02, A_CTRL = 8'h08;
  localparam logic [7:0]  A_STATUS = 8'h09, A_SEED = 8'h0a, A_WCNT = 8'h0b, A_RATE = 8'h10;

  logic       clk = 1'b0;
  logic       reset, noise, test_mode, debug_update;
  logic       security_error, entropy_enabled;
  logic [7:0] debug;
  logic       test_mode64, debug_update64, sec64, en64;
  logic [7:0] debug64;

  avalanche_entropy_model_if #(.DATA_WIDTH(32)) bus ();
  avalanche_entropy_model_if #(.DATA_WIDTH(64)) bus64 ();

  always #5 clk = ~clk;

  avalanche_entropy_model #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .noise           (noise),
    .test_mode       (test_mode),
    .security_error  (security_error),
    .entropy_enabled (entropy_enabled),
    .debug           (debug),
    .debug_update    (debug_update),
    .bus             (bus)
  );

  avalanche_entropy_model #(.DATA_WIDTH(64)) dut64 (
    .clk             (clk),
    .reset           (reset),
    .noise           (noise),
    .test_mode       (test_mode64),
    .security_error  (sec64),
    .entropy_enabled (en64),
    .debug           (debug64),
    .debug_update    (debug_update64),
    .bus             (bus64)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  // Behavioural model of the 32-bit instance.
  logic [31:0] m_lfsr, m_exp, m_last, m_count;
  logic        m_first, m_sec, m_fault;
  logic [31:0] rd;
  logic        er;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Next word the source should produce; the generator is frozen while fault is set.
  function automatic logic [31:0] next_word();
    logic [31:0] w;
    w = lfsr_step(m_lfsr);
    if (!m_fault) m_lfsr = w;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    bus.cs = 1'b1; bus.we = 1'b0; bus.address = a;
    #1;
    d = bus.read_data; e = bus.error;
    bus.cs = 1'b0;
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d, output logic e);
    bus.cs = 1'b1; bus.we = 1'b1; bus.address = a; bus.write_data = d;
    #1;
    e = bus.error;
    tick();
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  // Hold the current word a while, accept it, and time the arrival of the next one.
  task automatic handshake(input int hold, input int exp_lat);
    int cyc;
    for (int i = 0; i < hold; i++) tick();
    n_tests++;
    if (bus.entropy_valid !== 1'b1 || bus.entropy_data !== m_exp) begin
      n_fail++;
      $display("FAIL word: got valid=%b data=%h, exp valid=1 data=%h",
               bus.entropy_valid, bus.entropy_data, m_exp);
    end
    bus.entropy_ack = 1'b1;
    tick();
    bus.entropy_ack = 1'b0;
    m_count = m_count + 1;
    if (!m_first && m_exp == m_last) m_sec = 1'b1;
    m_last  = m_exp;
    m_first = 1'b0;
    n_tests++;
    if (bus.entropy_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_drop: got %b exp 0", bus.entropy_valid);
    end
    n_tests++;
    if (security_error !== m_sec) begin
      n_fail++;
      $display("FAIL sec_err: got %b exp %b", security_error, m_sec);
    end
    cyc = 0;
    while (bus.entropy_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc != exp_lat) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles exp %0d", cyc, exp_lat);
    end
    m_exp = next_word();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.entropy_valid !== 1'b0 || bus.entropy_data !== 32'h0 || debug !== 8'h00 ||
        security_error !== 1'b0 || entropy_enabled !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h dbg=%h se=%b en=%b exp 0 0 00 0 1",
               bus.entropy_valid, bus.entropy_data, debug, security_error, entropy_enabled);
    end
    reg_read(A_CTRL, rd, er);
    n_tests++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL reset_ctrl: got %h exp 1", rd); end
    reg_read(A_RATE, rd, er);
    n_tests++;
    if (rd !== 32'h4) begin n_fail++; $display("FAIL reset_rate: got %h exp 4", rd); end
    reg_read(A_WCNT, rd, er);
    n_tests++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_wcnt: got %h exp 0", rd); end
    reset = 1'b0;
    m_lfsr = SEED_DEF; m_first = 1'b1; m_sec = 1'b0; m_fault = 1'b0; m_count = 0;
    m_last = 0;
    m_exp  = next_word();
    tick();
    n_tests++;
    if (bus.entropy_valid !== 1'b1 || bus.entropy_data !== 32'h089119A2) begin
      n_fail++;
      $display("FAIL first_word: got v=%b d=%h exp v=1 d=089119a2",
               bus.entropy_valid, bus.entropy_data);
    end
    n_tests++;
    if (bus64.entropy_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_not_yet: got %b exp 0", bus64.entropy_valid);
    end
  endtask

  task automatic test_wide();
    logic [31:0] s3, s4;
    int cyc;
    tick();
    n_tests++;
    if (bus64.entropy_valid !== 1'b1 || bus64.entropy_data !== 64'h089119A2_04488CD1) begin
      n_fail++;
      $display("FAIL wide_first: got v=%b d=%h exp v=1 d=089119a204488cd1",
               bus64.entropy_valid, bus64.entropy_data);
    end
    s3 = lfsr_step(32'h04488CD1);
    s4 = lfsr_step(s3);
    bus64.entropy_ack = 1'b1;
    tick();
    bus64.entropy_ack = 1'b0;
    cyc = 0;
    while (bus64.entropy_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc != 6 || bus64.entropy_data !== {s3, s4}) begin
      n_fail++;
      $display("FAIL wide_second: got %0d cycles d=%h exp 6 cycles d=%h",
               cyc, bus64.entropy_data, {s3, s4});
    end
  endtask

  task automatic test_first_ack();
    handshake(0, 5);
    reg_read(A_WCNT, rd, er);
    n_tests++;
    if (rd !== m_count) begin n_fail++; $display("FAIL wcnt: got %h exp %h", rd, m_count); end
  endtask

  task automatic test_registers();
    reg_read(A_NAME0, rd, er);
    n_tests++;
    if (rd !== 32'h6176616c || er !== 1'b0) begin
      n_fail++; $display("FAIL name0: got %h err=%b exp 6176616c err=0", rd, er);
    end
    reg_read(A_NAME1, rd, er);
    n_tests++;
    if (rd !== 32'h66616b65) begin n_fail++; $display("FAIL name1: got %h exp 66616b65", rd); end
    reg_read(A_VER, rd, er);
    n_tests++;
    if (rd !== 32'h302e3230) begin n_fail++; $display("FAIL version: got %h exp 302e3230", rd); end
    reg_read(8'h05, rd, er);
    n_tests++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      n_fail++; $display("FAIL unmapped: got %h err=%b exp 0 err=1", rd, er);
    end
    reg_write(A_WCNT, 32'hdead, er);
    n_tests++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL ro_write_err: got %b exp 1", er); end
    reg_read(A_WCNT, rd, er);
    n_tests++;
    if (rd !== m_count) begin n_fail++; $display("FAIL ro_kept: got %h exp %h", rd, m_count); end
    reg_read(A_SEED, rd, er);
    n_tests++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL seed_read: got %h err=%b exp 0 err=0", rd, er);
    end
    reg_read(A_STATUS, rd, er);
    n_tests++;
    if (rd !== {30'h0, m_sec, 1'b1}) begin
      n_fail++; $display("FAIL status: got %h exp %h", rd, {30'h0, m_sec, 1'b1});
    end
  endtask

  task automatic test_rates();
    logic [7:0]  r;
    logic [31:0] s;
    logic        tm;
    for (int i = 0; i < 12; i++) begin
      r = 8'($urandom_range(0, 6));
      reg_write(A_RATE, {24'h0, r}, er);
      if ($urandom_range(0, 3) == 0) begin
        s = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
        reg_write(A_SEED, s, er);
        m_lfsr = (s == 32'h0) ? SEED_DEF : s;
      end
      tm = ($urandom_range(0, 3) == 0);
      test_mode = tm;
      handshake($urandom_range(0, 3), (tm || r == 8'd0) ? 1 : int'(r) + 1);
      test_mode = 1'b0;
    end
    reg_read(A_WCNT, rd, er);
    n_tests++;
    if (rd !== m_count) begin n_fail++; $display("FAIL wcnt_rates: got %h exp %h", rd, m_count); end
  endtask

  task automatic test_back_to_back();
    reg_write(A_RATE, 32'h0, er);
    for (int i = 0; i < 4; i++) handshake(0, 1);
  endtask

  task automatic test_disable();
    int cyc;
    reg_write(A_CTRL, 32'h0, er);
    n_tests++;
    if (entropy_enabled !== 1'b0) begin
      n_fail++; $display("FAIL disable_en: got %b exp 0", entropy_enabled);
    end
    tick();
    n_tests++;
    if (bus.entropy_valid !== 1'b0 || bus.entropy_data !== m_exp) begin
      n_fail++;
      $display("FAIL disable_valid: got v=%b d=%h exp v=0 d=%h",
               bus.entropy_valid, bus.entropy_data, m_exp);
    end
    repeat (3) tick();
    reg_write(A_CTRL, 32'h1, er);
    cyc = 0;
    while (bus.entropy_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc != 2) begin n_fail++; $display("FAIL reenable: got %0d cycles exp 2", cyc); end
    m_exp = next_word();  // held word was never accepted; a fresh one replaces it
    handshake(1, 1);
  endtask

  task automatic test_fault();
    reg_write(A_CTRL, 32'h3, er);
    m_fault = 1'b1;
    handshake(0, 1);
    handshake(0, 1);
    handshake(0, 1);
    n_tests++;
    if (security_error !== 1'b1) begin
      n_fail++; $display("FAIL fault_repeat: got %b exp 1", security_error);
    end
    reg_write(A_CTRL, 32'h1, er);
    m_fault = 1'b0;
    reg_write(A_STATUS, 32'h2, er);
    m_sec = 1'b0;
    n_tests++;
    if (security_error !== 1'b0) begin
      n_fail++; $display("FAIL sec_clear: got %b exp 0", security_error);
    end
    reg_read(A_STATUS, rd, er);
    n_tests++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL status_clear: got %h exp 1", rd); end
  endtask

  task automatic test_debug();
    debug_update = 1'b1;
    tick();
    debug_update = 1'b0;
    n_tests++;
    if (debug !== m_lfsr[7:0]) begin
      n_fail++; $display("FAIL debug: got %h exp %h", debug, m_lfsr[7:0]);
    end
  endtask

  initial begin
    reset = 1'b1; noise = 1'b0; test_mode = 1'b0; debug_update = 1'b0;
    test_mode64 = 1'b0; debug_update64 = 1'b0;
    bus.cs = 1'b0; bus.we = 1'b0; bus.address = 8'h0; bus.write_data = 32'h0;
    bus.entropy_ack = 1'b0;
    bus64.cs = 1'b0; bus64.we = 1'b0; bus64.address = 8'h0; bus64.write_data = 32'h0;
    bus64.entropy_ack = 1'b0;
    test_reset();
    test_wide();
    test_first_ack();
    test_registers();
    test_rates();
    test_back_to_back();
    test_disable();
    test_fault();
    test_debug();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
